// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and the SRAM slave state enum
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } sram_state_e;

endpackage

// File: rtl/ahb_bytemask.sv
// rtl/ahb_bytemask.sv - byte-lane enable mask from (offset, HSIZE)
module ahb_bytemask #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 2
) (
    input  logic [OFF_W-1:0]    offset,
    input  logic [2:0]          size,
    output logic [DATA_W/8-1:0] mask
);

    localparam int BYTES = DATA_W / 8;

    always_comb begin
        mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            mask[i] = (i >= int'(offset)) && (i < int'(offset) + (1 << size));
        end
    end

endmodule

// File: rtl/ahb_sram.sv
// rtl/ahb_sram.sv - AHB-Lite single-port SRAM slave with wait states and ERROR response
module ahb_sram
    import ahb_pkg::*;
#(
    parameter int          DATA_W         = 32,
    parameter int          ADDR_W         = 17,
    parameter int          DEPTH          = 256,
    parameter int unsigned BASE           = 0,
    parameter int          WAIT_STATES    = 0,
    parameter int          CLEAR_ON_RESET = 1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int          BYTES    = DATA_W / 8;
    localparam int          SHIFT    = $clog2(BYTES);
    localparam int          OFF_W    = (BYTES > 1) ? SHIFT : 1;
    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  MAX_SIZE = 3'(SHIFT);
    localparam logic [63:0] BASE_L   = 64'(BASE);
    localparam logic [63:0] END_L    = BASE_L + 64'(DEPTH) * 64'(BYTES);

    sram_state_e       state, state_n;
    logic [IDX_W-1:0]  cnt, cnt_n;
    logic [3:0]        wcnt, wcnt_n;
    logic              dp_valid, dp_valid_n;
    logic [IDX_W-1:0]  dp_idx, dp_idx_n;
    logic [OFF_W-1:0]  dp_off, dp_off_n;
    logic [2:0]        dp_size, dp_size_n;
    logic              dp_write, dp_write_n;
    logic              dp_err, dp_err_n;

    logic [63:0]       addr_ext;
    logic [6:0]        align_mask;
    logic              in_range, misaligned, req_err, accept;
    logic              rd_active, do_write, do_clear;
    logic [BYTES-1:0]  lane_en;

    logic [DATA_W-1:0] mem [DEPTH];

    assign addr_ext   = 64'(HADDR);
    assign in_range   = (addr_ext >= BASE_L) && (addr_ext < END_L);
    assign align_mask = 7'((8'd1 << HSIZE) - 8'd1);
    assign misaligned = |(addr_ext[6:0] & align_mask);
    assign req_err    = !in_range || (HSIZE > MAX_SIZE) || misaligned;
    assign accept     = HSEL && HREADY &&
                        (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        wcnt_n     = wcnt;
        dp_valid_n = dp_valid;
        dp_idx_n   = dp_idx;
        dp_off_n   = dp_off;
        dp_size_n  = dp_size;
        dp_write_n = dp_write;
        dp_err_n   = dp_err;
        case (state)
            ST_CLEAR: begin
                cnt_n = cnt + 1'b1;
                if (cnt == IDX_W'(DEPTH - 1)) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            end
            ST_WAIT: begin
                if (wcnt == 4'd0) state_n = ST_DONE;
                else              wcnt_n  = wcnt - 4'd1;
            end
            ST_ERR1: state_n = ST_ERR2;
            default: begin
                // IDLE, DONE and ERR2 all finish the current data phase this cycle
                state_n    = ST_IDLE;
                dp_valid_n = 1'b0;
                if (accept) begin
                    dp_valid_n = 1'b1;
                    dp_idx_n   = IDX_W'((addr_ext - BASE_L) >> SHIFT);
                    dp_off_n   = OFF_W'(addr_ext & 64'(BYTES - 1));
                    dp_size_n  = HSIZE;
                    dp_write_n = HWRITE;
                    dp_err_n   = req_err;
                    if (req_err) begin
                        state_n = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_n = ST_WAIT;
                        wcnt_n  = 4'(WAIT_STATES - 1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt      <= '0;
            wcnt     <= '0;
            dp_valid <= 1'b0;
            dp_idx   <= '0;
            dp_off   <= '0;
            dp_size  <= '0;
            dp_write <= 1'b0;
            dp_err   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            wcnt     <= wcnt_n;
            dp_valid <= dp_valid_n;
            dp_idx   <= dp_idx_n;
            dp_off   <= dp_off_n;
            dp_size  <= dp_size_n;
            dp_write <= dp_write_n;
            dp_err   <= dp_err_n;
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state)
            ST_CLEAR, ST_WAIT: HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    ahb_bytemask #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_bytemask (
        .offset (dp_off),
        .size   (dp_size),
        .mask   (lane_en)
    );

    // Writes land only in the completing cycle, so a mid-transfer reset drops them
    assign do_write  = dp_valid && !dp_err && dp_write && !HRESET &&
                       (state == ST_IDLE || state == ST_DONE);
    assign do_clear  = (state == ST_CLEAR) && !HRESET;
    assign rd_active = dp_valid && !dp_err && !dp_write &&
                       (state == ST_IDLE || state == ST_WAIT || state == ST_DONE);

    always_ff @(posedge HCLK) begin
        if (do_clear) begin
            mem[cnt] <= '0;
        end else if (do_write) begin
            for (int i = 0; i < BYTES; i++) begin
                if (lane_en[i]) mem[dp_idx][i*8 +: 8] <= HWDATA[i*8 +: 8];
            end
        end
    end

    assign HRDATA = rd_active ? mem[dp_idx] : '0;

endmodule

// File: tb/tb_ahb_sram.sv
// tb/tb_ahb_sram.sv - directed self-checking bench for ahb_sram
module tb_ahb_sram;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, sel0, sel1;
    logic [16:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] rd0, rd1;
    logic        ho0, ho1, hr0, hr1;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    int          lowc;
    logic        resp1, respn;

    ahb_sram #(.DATA_W(32), .ADDR_W(17), .DEPTH(256), .BASE(32'h1000),
               .WAIT_STATES(0), .CLEAR_ON_RESET(1)) dut0 (
        .HCLK(clk), .HRESET(rst0), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ho0),
        .HRDATA(rd0), .HREADYOUT(ho0), .HRESP(hr0));

    ahb_sram #(.DATA_W(32), .ADDR_W(17), .DEPTH(256), .BASE(32'h1000),
               .WAIT_STATES(3), .CLEAR_ON_RESET(0)) dut1 (
        .HCLK(clk), .HRESET(rst1), .HSEL(sel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ho1),
        .HRDATA(rd1), .HREADYOUT(ho1), .HRESP(hr1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer; reports read data and HRESP seen in the completing cycle
    task automatic xfer(input int s, input logic wr, input logic [16:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] r, output int lc,
                        output logic rs1, output logic rsn);
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
        htrans = HTRANS_NONSEQ;
        sel0   = (s == 0);
        sel1   = (s == 1);
        @(posedge clk); #1;
        htrans = HTRANS_IDLE;
        sel0   = 1'b0;
        sel1   = 1'b0;
        hwdata = wd;
        rs1    = (s == 0) ? hr0 : hr1;
        lc     = 0;
        while (((s == 0) ? ho0 : ho1) == 1'b0 && lc < 32) begin
            @(posedge clk); #1;
            lc++;
        end
        r   = (s == 0) ? rd0 : rd1;
        rsn = (s == 0) ? hr0 : hr1;
        @(posedge clk); #1;
    endtask

    logic [16:0] err_addr [3];
    logic [2:0]  err_size [3];

    initial begin
        err_addr = '{17'h1400, 17'h1001, 17'h1000};
        err_size = '{HSIZE_WORD, HSIZE_HALF, HSIZE_DWORD};
        rst0 = 1'b1; rst1 = 1'b1; sel0 = 1'b0; sel1 = 1'b0;
        haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hreadyout0", 32'(ho0), 32'd0);
        check("rst_hresp0", 32'(hr0), 32'd0);
        check("rst_hrdata0", rd0, 32'd0);
        check("rst_hreadyout1", 32'(ho1), 32'd1);
        rst0 = 1'b0;
        rst1 = 1'b0;

        lowc = 0;
        while (!ho0 && lowc < 1000) begin
            @(posedge clk); #1;
            lowc++;
        end
        check("clear_cycles", 32'(lowc), 32'd256);

        xfer(0, 1'b0, 17'h1010, HSIZE_WORD, 32'h0, rd, lowc, resp1, respn);
        check("clear_read_data", rd, 32'h0);
        check("clear_read_lat", 32'(lowc), 32'd0);

        xfer(0, 1'b1, 17'h1004, HSIZE_WORD, 32'hDEADBEEF, rd, lowc, resp1, respn);
        xfer(0, 1'b1, 17'h1006, HSIZE_BYTE, 32'hAAAAAAAA, rd, lowc, resp1, respn);
        xfer(0, 1'b0, 17'h1004, HSIZE_WORD, 32'h0, rd, lowc, resp1, respn);
        check("byte_merge", rd, 32'hDEAABEEF);
        check("byte_merge_resp", 32'(respn), 32'd0);

        haddr = 17'h1008; hwrite = 1'b1; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ; sel0 = 1'b1;
        @(posedge clk); #1;
        hwdata = 32'h12345678;
        hwrite = 1'b0;
        check("b2b_wr_ready", 32'(ho0), 32'd1);
        @(posedge clk); #1;
        htrans = HTRANS_IDLE;
        sel0   = 1'b0;
        check("b2b_rd_ready", 32'(ho0), 32'd1);
        check("b2b_rd_data", rd0, 32'h12345678);
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            xfer(0, 1'b1, err_addr[i], err_size[i], 32'hFFFFFFFF, rd, lowc, resp1, respn);
            check($sformatf("err%0d_low", i), 32'(lowc), 32'd1);
            check($sformatf("err%0d_resp1", i), 32'(resp1), 32'd1);
            check($sformatf("err%0d_resp2", i), 32'(respn), 32'd1);
            xfer(0, 1'b0, 17'h1000, HSIZE_WORD, 32'h0, rd, lowc, resp1, respn);
            check($sformatf("err%0d_mem", i), rd, 32'h0);
        end
        xfer(0, 1'b0, 17'h0FFC, HSIZE_WORD, 32'h0, rd, lowc, resp1, respn);
        check("err_rd_data", rd, 32'h0);
        check("err_rd_resp", 32'(respn), 32'd1);

        xfer(1, 1'b1, 17'h1000, HSIZE_WORD, 32'hCAFEF00D, rd, lowc, resp1, respn);
        check("ws_wr_low", 32'(lowc), 32'd3);
        xfer(1, 1'b0, 17'h1000, HSIZE_WORD, 32'h0, rd, lowc, resp1, respn);
        check("ws_rd_low", 32'(lowc), 32'd3);
        check("ws_rd_data", rd, 32'hCAFEF00D);
        check("ws_rd_resp", 32'(respn), 32'd0);

        xfer(1, 1'b1, 17'h1020, HSIZE_WORD, 32'h11111111, rd, lowc, resp1, respn);
        haddr = 17'h1020; hwrite = 1'b1; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ; sel1 = 1'b1;
        @(posedge clk); #1;
        htrans = HTRANS_IDLE;
        sel1   = 1'b0;
        hwdata = 32'h22222222;
        check("midrst_wait", 32'(ho1), 32'd0);
        rst1 = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 32'(ho1), 32'd1);
        check("midrst_hresp", 32'(hr1), 32'd0);
        check("midrst_hrdata", rd1, 32'd0);
        @(posedge clk); #1;
        rst1 = 1'b0;
        xfer(1, 1'b0, 17'h1020, HSIZE_WORD, 32'h0, rd, lowc, resp1, respn);
        check("midrst_mem", rd, 32'h11111111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
